uart_word_tx: RTL
=================

// Module: uart_word_tx
// PURPOSE
//   Downstream consumer of the skidbuffer word stream. Accepts DATA_SIZE-bit words over
//   valid/ready and serialises each word onto a UART tx line as DATA_SIZE/8 bytes,
//   least-significant byte first, each byte 8N1 (8-bit data, no parity, 1 stop bit).
//   Back-pressures the buffer through in_ready while a word is on the wire.
// PARAMETERS
//   DATA_SIZE     16   word width; must be a multiple of 8 and >= 8
//   CLKS_PER_BIT  868  clk cycles per UART bit, >= 2 (868 = 100 MHz / 115200)
// PORTS
//   clk         in   1          clock; all logic on posedge
//   rst_n       in   1          asynchronous active-low reset
//   in_valid    in   1          word available (skidbuffer out_valid)
//   in_data     in   DATA_SIZE  word (skidbuffer out_data)
//   in_ready    out  1          registered; drives skidbuffer out_ready
//   tx          out  1          registered UART line; idle high
//   words_sent  out  16         count of fully transmitted words; wraps
// BEHAVIOUR
//   - Reset (async assert): tx=1, in_ready=1, words_sent=0, state IDLE, counters 0.
//     Abort mid-frame takes effect immediately; no partial byte is completed.
//   - Handshake: transfer on posedge with in_valid && in_ready. Latch in_data into the
//     shift register, clear in_ready at that same edge, go to START. in_data is ignored
//     while in_ready=0.
//   - FSM: IDLE -> START -> DATA -> STOP -> (START | IDLE)
//     IDLE : tx=1, in_ready=1; waits for the handshake.
//     START: tx=0 for CLKS_PER_BIT cycles.
//     DATA : 8 bits LSB-first, each held CLKS_PER_BIT cycles; bit index 0..7.
//     STOP : tx=1 for CLKS_PER_BIT cycles. On its last cycle: if bytes remain, go to
//            START of the next byte; otherwise go to IDLE, set in_ready=1 and increment
//            words_sent (modulo 2^16).
//   - Baud counter: width $clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1 and restarts
//     at every bit boundary. Byte index width $clog2(DATA_SIZE/8) (min 1).
//   - Timing: first start bit appears on tx the cycle after acceptance. Inter-byte gap
//     within a word is 0. Exactly 1 idle cycle (tx=1, in_ready=1) separates words, so a
//     continuously valid stream has word period BYTES*FRAME_BITS*CLKS_PER_BIT + 1 cycles
//     (FRAME_BITS=10).
//   - Empty upstream: stays in IDLE indefinitely, tx=1.
//   - DATA_SIZE not a multiple of 8: elaboration error (generate-time $error).
// CONFIGURATION
//   UART_TX_PARITY_EN defined: a PARITY state is inserted between DATA and STOP. It
//     drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles, and
//     FRAME_BITS=11.
//   Undefined: no PARITY state, FRAME_BITS=10, no parity logic synthesised.
// TESTING (DATA_SIZE=16, CLKS_PER_BIT=4 unless noted)
//   1 Reset: hold rst_n=0 -> tx=1, in_ready=1, words_sent=0; release -> unchanged.
//   2 Single word 16'hA55A -> tx bits (1 per 4 clk) 0,01011010,1 then 0,10100101,1
//     (LSB first). in_ready low for exactly 80 cycles. words_sent=1.
//   3 in_valid held with words 16'h0001, 16'hFFFF -> second handshake exactly 81 cycles
//     after the first; words_sent=2 after 162 cycles; in_data changes mid-word ignored.
//   4 rst_n pulsed low during DATA bit 3 of byte 0 -> tx=1 in the same cycle; after
//     release in_ready=1, words_sent unchanged at 0, next word sent intact.
//   5 UART_TX_PARITY_EN, word 16'h015A -> parity bit 0 for byte 8'h5A, 1 for byte 8'h01;
//     word period 89 cycles.
//   6 CLKS_PER_BIT=2, DATA_SIZE=8, 16'h10000 words via wrap test: words_sent wraps
//     FFFF -> 0000.

Source files
------------

// File: rtl/uart_word_if.sv
// Word stream handshake between the skidbuffer (master) and the UART word transmitter (slave).
interface uart_word_if #(
  parameter int DATA_SIZE = 16
);
  logic                 in_valid;
  logic [DATA_SIZE-1:0] in_data;
  logic                 in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/uart_word_tx.sv
// Serialises DATA_SIZE-bit words onto a UART line as 8N1 bytes, least-significant byte first.
// Define UART_TX_PARITY_EN to insert an even-parity bit after each byte's data bits.
module uart_word_tx #(
  parameter int DATA_SIZE    = 16,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_word_if.slave    bus,
  output logic          tx,
  output logic [15:0]   words_sent
);

  localparam int BYTES  = DATA_SIZE / 8;
  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BAUD_W-1:0] BAUD_MAX  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BYTES - 1);

  generate
    if ((DATA_SIZE % 8) != 0 || DATA_SIZE < 8) begin : g_bad_size
      $error("uart_word_tx: DATA_SIZE must be a non-zero multiple of 8");
    end
  endgenerate

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state_reg,  state_next;
  logic [BAUD_W-1:0]    baud_reg,   baud_next;
  logic [2:0]           bit_reg,    bit_next;
  logic [BYTE_W-1:0]    byte_reg,   byte_next;
  logic [DATA_SIZE-1:0] shift_reg,  shift_next;
  logic                 tx_reg,     tx_next;
  logic                 ready_reg,  ready_next;
  logic [15:0]          words_reg,  words_next;
  logic                 baud_last;

  assign baud_last    = (baud_reg == BAUD_MAX);
  assign bus.in_ready = ready_reg;
  assign tx           = tx_reg;
  assign words_sent   = words_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      byte_reg  <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
      ready_reg <= 1'b1;
      words_reg <= '0;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      byte_reg  <= byte_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
      ready_reg <= ready_next;
      words_reg <= words_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    byte_next  = byte_reg;
    shift_next = shift_reg;
    ready_next = ready_reg;
    words_next = words_reg;

    if (state_reg == IDLE) begin
      if (bus.in_valid && ready_reg) begin
        shift_next = bus.in_data;
        ready_next = 1'b0;
        baud_next  = '0;
        bit_next   = '0;
        byte_next  = '0;
        state_next = START;
      end
    end else if (!baud_last) begin
      baud_next = baud_reg + BAUD_W'(1);
    end else begin
      baud_next = '0;
      case (state_reg)
        START: begin
          bit_next   = '0;
          state_next = DATA;
        end
        DATA: begin
          if (bit_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: state_next = STOP;
`endif
        STOP: begin
          if (byte_reg == LAST_BYTE) begin
            state_next = IDLE;
            ready_next = 1'b1;
            words_next = words_reg + 16'd1;
          end else begin
            // Next byte moves into the low bits so DATA always reads shift_reg[7:0].
            byte_next  = byte_reg + BYTE_W'(1);
            shift_next = shift_reg >> 8;
            state_next = START;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // tx is registered from the next state so the line leads the FSM by no cycle.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:  tx_next = 1'b0;
      DATA:   tx_next = shift_next[bit_next];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_next = ^shift_next[7:0];
`endif
      default: tx_next = 1'b1;
    endcase
  end

endmodule
